draw_scheduler: RTL and testbench

- Owns the single VGA pixel write port and sequences the ball, brick and platform drawers through one frame: an erase pass, a logic-update window, then a colour pass.
- Replaces the fixed per-drawer delay counts with a go/done handshake, and adds a watchdog so that a hung drawer cannot stall the frame.
- Sits between the drawers and the `draw` module; the delay counter drives `frame_tick`.

---
 rtl/draw_scheduler_pkg.sv | 28 ++
 rtl/draw_scheduler_if.sv | 17 +
 rtl/draw_scheduler_port_mux.sv | 55 +++++
 rtl/draw_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the draw scheduler: slot/state encodings and pixel bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package draw_scheduler_pkg;

    localparam int COORD_W   = 10;
    localparam int COLOUR_W  = 3;
    localparam int NUM_SLOTS = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    // Fixed grant order within a pass: ball, bricks, platform.
    typedef enum logic [1:0] {
        SLOT_BALL  = 2'd0,
        SLOT_BRICK = 2'd1,
        SLOT_PLAT  = 2'd2
    } slot_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_GO         = 3'd1,
        S_WAIT       = 3'd2,
        S_NEXT       = 3'd3,
        S_LOGIC      = 3'd4,
        S_LOGIC_WAIT = 3'd5
    } state_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// One drawer channel: go/done handshake plus that drawer's pixel write request.
// Latency: n/a (wires only).
// Backpressure: none; the scheduler grants one channel at a time via go.
// Ports: go (scheduler->drawer), done, x, y, colour, en (drawer->scheduler).
interface draw_scheduler_if;
    import draw_scheduler_pkg::*;

    logic                go;
    logic                done;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
    logic                en;

    modport master (output go, input done, input x, input y, input colour, input en);
    modport slave  (input go, output done, output x, output y, output colour, output en);
endinterface

// File: rtl/draw_scheduler_port_mux.sv
// Combinational pixel-port mux: forwards the granted drawer's pixel to the VGA write port.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ungranted drawers are simply not forwarded.
// Ports: slot/grant/iscolour select, per-slot xs/ys/colours/ens in, x/y/colour/write_en out.
module draw_scheduler_port_mux
    import draw_scheduler_pkg::*;
(
    input  slot_t                               slot,
    input  logic                                grant,
    input  logic                                iscolour,
    input  logic [NUM_SLOTS-1:0][COORD_W-1:0]   xs,
    input  logic [NUM_SLOTS-1:0][COORD_W-1:0]   ys,
    input  logic [NUM_SLOTS-1:0][COLOUR_W-1:0]  colours,
    input  logic [NUM_SLOTS-1:0]                ens,
    output logic [COORD_W-1:0]                  x,
    output logic [COORD_W-1:0]                  y,
    output logic [COLOUR_W-1:0]                 colour,
    output logic                                write_en
);

    logic [COORD_W-1:0]  sel_x;
    logic [COORD_W-1:0]  sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_en;

    always_comb begin
        sel_x      = xs[0];
        sel_y      = ys[0];
        sel_colour = colours[0];
        sel_en     = ens[0];
        case (slot)
            SLOT_BRICK: begin
                sel_x      = xs[1];
                sel_y      = ys[1];
                sel_colour = colours[1];
                sel_en     = ens[1];
            end
            SLOT_PLAT: begin
                sel_x      = xs[2];
                sel_y      = ys[2];
                sel_colour = colours[2];
                sel_en     = ens[2];
            end
            default: ;
        endcase
    end

    // Outside a grant the port reads all-zero so nothing stray reaches the frame buffer.
    // The erase pass paints with the drawer's own coordinates but always in black.
    assign x        = grant ? sel_x : '0;
    assign y        = grant ? sel_y : '0;
    assign colour   = (grant && iscolour) ? sel_colour : BLACK;
    assign write_en = grant & sel_en;

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer owning the VGA write port: erase pass, logic window, colour pass, with a per-drawer watchdog.
// Latency: frame_tick in idle -> go_ball 2 cycles later; go/inc_enable/timeout_err/frame_overrun are registered pulses.
// Backpressure: none upstream; one frame request is queued while busy, further requests are dropped and flagged.
// Ports: clk, reset; frame_tick in; ball/bricks/plat drawer channels; x, y, colour, writeEn, iscolour,
//        inc_enable, busy, timeout_err, frame_overrun out.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int TIMEOUT          = 4096,
    parameter int LOGIC_CYCLES     = 12,
    parameter bit SKIP_BRICK_ERASE = 1'b1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    draw_scheduler_if.master       ball,
    draw_scheduler_if.master       bricks,
    draw_scheduler_if.master       plat,
    output logic [COORD_W-1:0]     x,
    output logic [COORD_W-1:0]     y,
    output logic [COLOUR_W-1:0]    colour,
    output logic                   writeEn,
    output logic                   iscolour,
    output logic                   inc_enable,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   frame_overrun
);

    // One counter serves both the drawer watchdog and the logic window.
    localparam int CNT_MAX = (TIMEOUT > LOGIC_CYCLES) ? TIMEOUT : LOGIC_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOGIC_LAST = CNT_W'(LOGIC_CYCLES - 1);

    state_t           state, state_nxt;
    slot_t            slot, slot_nxt;
    logic             iscolour_nxt;
    logic             pending, pending_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             go_fire, inc_fire, tmo_fire, ovr_fire;
    logic             done_sel;
    logic             go_ball_q, go_bricks_q, go_plat_q;

    assign busy      = (state != S_IDLE);
    assign ball.go   = go_ball_q;
    assign bricks.go = go_bricks_q;
    assign plat.go   = go_plat_q;

    // Only the granted drawer's done is looked at.
    always_comb begin
        case (slot)
            SLOT_BRICK: done_sel = bricks.done;
            SLOT_PLAT:  done_sel = plat.done;
            default:    done_sel = ball.done;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        slot_nxt     = slot;
        iscolour_nxt = iscolour;
        cnt_nxt      = cnt;
        go_fire      = 1'b0;
        inc_fire     = 1'b0;
        tmo_fire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending || frame_tick) begin
                    state_nxt    = S_GO;
                    slot_nxt     = SLOT_BALL;
                    iscolour_nxt = 1'b0;
                end
            end
            S_GO: begin
                go_fire   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done on the last watchdog cycle still counts as a clean finish.
                if (done_sel) begin
                    state_nxt = S_NEXT;
                end else if (cnt == TMO_LAST) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_NEXT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_NEXT: begin
                case (slot)
                    SLOT_BALL: begin
                        state_nxt = S_GO;
                        slot_nxt  = (!iscolour && SKIP_BRICK_ERASE) ? SLOT_PLAT : SLOT_BRICK;
                    end
                    SLOT_BRICK: begin
                        state_nxt = S_GO;
                        slot_nxt  = SLOT_PLAT;
                    end
                    default: state_nxt = iscolour ? S_IDLE : S_LOGIC;
                endcase
            end
            S_LOGIC: begin
                inc_fire  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_LOGIC_WAIT;
            end
            S_LOGIC_WAIT: begin
                if (cnt == LOGIC_LAST) begin
                    iscolour_nxt = 1'b1;
                    slot_nxt     = SLOT_BALL;
                    state_nxt    = S_GO;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One-deep frame request queue. In idle a queued request is consumed while a
    // simultaneous new tick takes its place, so neither is lost.
    always_comb begin
        pending_nxt = pending;
        ovr_fire    = 1'b0;
        if (state == S_IDLE) begin
            if (pending) begin
                pending_nxt = frame_tick;
            end
        end else if (frame_tick) begin
            if (pending) begin
                ovr_fire = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            slot          <= SLOT_BALL;
            iscolour      <= 1'b0;
            pending       <= 1'b0;
            cnt           <= '0;
            go_ball_q     <= 1'b0;
            go_bricks_q   <= 1'b0;
            go_plat_q     <= 1'b0;
            inc_enable    <= 1'b0;
            timeout_err   <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            slot          <= slot_nxt;
            iscolour      <= iscolour_nxt;
            pending       <= pending_nxt;
            cnt           <= cnt_nxt;
            go_ball_q     <= go_fire && (slot == SLOT_BALL);
            go_bricks_q   <= go_fire && (slot == SLOT_BRICK);
            go_plat_q     <= go_fire && (slot == SLOT_PLAT);
            inc_enable    <= inc_fire;
            timeout_err   <= tmo_fire;
            frame_overrun <= ovr_fire;
        end
    end

    draw_scheduler_port_mux u_port_mux (
        .slot     (slot),
        .grant    ((state == S_GO) || (state == S_WAIT)),
        .iscolour (iscolour),
        .xs       ({plat.x, bricks.x, ball.x}),
        .ys       ({plat.y, bricks.y, ball.y}),
        .colours  ({plat.colour, bricks.colour, ball.colour}),
        .ens      ({plat.en, bricks.en, ball.en}),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .write_en (writeEn)
    );

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected pulse events are queued by the stimulus and
// consumed by an independent monitor; pixel-port values are compared at directed points.
// Drawers are modelled as responders that raise done a fixed number of cycles after go.
`timescale 1ns/1ps
module tb_draw_scheduler;
    import draw_scheduler_pkg::*;

    localparam int EV_GO_BALL  = 1;
    localparam int EV_GO_BRICK = 2;
    localparam int EV_GO_PLAT  = 3;
    localparam int EV_INC      = 4;
    localparam int EV_TMO      = 5;
    localparam int EV_OVR      = 6;

    // kind 0: order only; 1: cycles after previous event; 2: absolute cycle
    typedef struct {
        int code;
        int kind;
        int when;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic [COORD_W-1:0]  x, y;
    logic [COLOUR_W-1:0] colour;
    logic writeEn, iscolour, inc_enable, busy, timeout_err, frame_overrun;

    draw_scheduler_if ball_if();
    draw_scheduler_if bricks_if();
    draw_scheduler_if plat_if();

    logic ball_done_auto = 1'b0, bricks_done_auto = 1'b0, plat_done_auto = 1'b0, plat_done_inj = 1'b0;
    assign ball_if.done   = ball_done_auto;
    assign bricks_if.done = bricks_done_auto;
    assign plat_if.done   = plat_done_auto | plat_done_inj;

    int d_ball = 5, d_bricks = 5, d_plat = 5;
    int cyc = 0, tick_cyc = 0, last_ev = 0;
    int checks = 0, errors = 0;
    int t0, t1, t2, t3, t4;
    exp_t exp_q[$];

    draw_scheduler #(.TIMEOUT(16), .LOGIC_CYCLES(12), .SKIP_BRICK_ERASE(1'b1)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .ball(ball_if), .bricks(bricks_if), .plat(plat_if),
        .x(x), .y(y), .colour(colour), .writeEn(writeEn), .iscolour(iscolour),
        .inc_enable(inc_enable), .busy(busy), .timeout_err(timeout_err), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int code, int kind, int when);
        exp_t e;
        e.code = code;
        e.kind = kind;
        e.when = when;
        exp_q.push_back(e);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic observe(int code, string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: pulse at cycle %0d, required none", name, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.code != code) begin
                errors++;
                $display("FAIL event_order: got %s (code %0d) at cycle %0d, required code %0d", name, code, cyc, e.code);
            end else if (e.kind == 1 && cyc != last_ev + e.when) begin
                errors++;
                $display("FAIL %s_timing: got %0d cycles after previous event, required %0d", name, cyc - last_ev, e.when);
            end else if (e.kind == 2 && cyc != e.when) begin
                errors++;
                $display("FAIL %s_timing: got cycle %0d, required cycle %0d", name, cyc, e.when);
            end
        end
        last_ev = cyc;
    endtask

    // Monitor: decoupled from stimulus, consumes the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (ball_if.go)    observe(EV_GO_BALL, "go_ball");
            if (bricks_if.go)  observe(EV_GO_BRICK, "go_bricks");
            if (plat_if.go)    observe(EV_GO_PLAT, "go_plat");
            if (inc_enable)    observe(EV_INC, "inc_enable");
            if (timeout_err)   observe(EV_TMO, "timeout_err");
            if (frame_overrun) observe(EV_OVR, "frame_overrun");
        end
    end

    // Drawer responders; a negative delay means the drawer never finishes.
    initial forever begin
        @(negedge clk);
        if (ball_if.go && d_ball >= 0) begin
            repeat (d_ball) @(posedge clk);
            #1 ball_done_auto = 1'b1;
            @(posedge clk);
            #1 ball_done_auto = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (bricks_if.go && d_bricks >= 0) begin
            repeat (d_bricks) @(posedge clk);
            #1 bricks_done_auto = 1'b1;
            @(posedge clk);
            #1 bricks_done_auto = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (plat_if.go && d_plat >= 0) begin
            repeat (d_plat) @(posedge clk);
            #1 plat_done_auto = 1'b1;
            @(posedge clk);
            #1 plat_done_auto = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1 frame_tick = 1'b1;
        tick_cyc = cyc;
        @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    // Full frame with 5-cycle drawers, go_ball already queued by the caller.
    function automatic void push_rest_of_frame();
        push(EV_GO_PLAT, 1, 8);
        push(EV_INC, 1, 8);
        push(EV_GO_BALL, 1, 13);
        push(EV_GO_BRICK, 1, 8);
        push(EV_GO_PLAT, 1, 8);
    endfunction

    task automatic check_all_zero(string name);
        chk(name, {x, y, colour, writeEn, iscolour, inc_enable, busy, timeout_err, frame_overrun,
                   ball_if.go, bricks_if.go, plat_if.go}, 32'h0);
    endtask

    initial begin
        ball_if.x = 10'd100;   ball_if.y = 10'd50;   ball_if.colour = 3'b101;   ball_if.en = 1'b1;
        bricks_if.x = 10'd200; bricks_if.y = 10'd60; bricks_if.colour = 3'b011; bricks_if.en = 1'b1;
        plat_if.x = 10'd300;   plat_if.y = 10'd70;   plat_if.colour = 3'b110;   plat_if.en = 1'b0;

        #3 check_all_zero("reset_outputs");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_after_release", busy, 1'b0);

        // Frame 1: normal sequence, erase colour, isolation of other slots.
        tick();
        t0 = tick_cyc;
        push(EV_GO_BALL, 2, t0 + 2);
        push_rest_of_frame();
        @(posedge clk);
        @(posedge clk);
        #1 plat_done_inj = 1'b1;               // foreign done during the ball grant
        @(negedge clk);
        chk("erase_x", x, 10'd100);
        chk("erase_y", y, 10'd50);
        chk("erase_colour", colour, 3'b000);
        chk("erase_write_en", writeEn, 1'b1);
        chk("erase_iscolour", iscolour, 1'b0);
        @(posedge clk);
        #1 plat_done_inj = 1'b0;
        ball_if.en = 1'b0;                     // bricks still requesting
        @(negedge clk);
        chk("isolation_write_en", writeEn, 1'b0);
        @(posedge clk);
        #1 ball_if.en = 1'b1;
        repeat (27) @(posedge clk);            // colour-pass ball grant
        @(negedge clk);
        chk("colour_ball_colour", colour, 3'b101);
        chk("colour_iscolour", iscolour, 1'b1);
        chk("colour_ball_write_en", writeEn, 1'b1);
        repeat (8) @(posedge clk);             // colour-pass bricks grant
        @(negedge clk);
        chk("colour_bricks_colour", colour, 3'b011);
        chk("colour_bricks_x", x, 10'd200);
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("frame_end_busy", busy, 1'b0);
        chk("frame_end_write_en", writeEn, 1'b0);

        // Frame 2: ball finishes on the last watchdog cycle; bricks hang.
        d_ball = 15;
        d_bricks = -1;
        tick();
        t1 = tick_cyc;
        push(EV_GO_BALL, 2, t1 + 2);
        push(EV_GO_PLAT, 1, 18);
        push(EV_INC, 1, 8);
        push(EV_GO_BALL, 1, 13);
        push(EV_GO_BRICK, 1, 18);
        push(EV_TMO, 1, 16);
        push(EV_GO_PLAT, 1, 2);
        repeat (90) @(posedge clk);
        d_ball = 5;
        d_bricks = 5;

        // Frame 3: one queued request, one overrun.
        tick();
        t2 = tick_cyc;
        push(EV_GO_BALL, 2, t2 + 2);
        tick();
        tick();
        push(EV_OVR, 2, t2 + 5);
        push(EV_GO_PLAT, 2, t2 + 10);
        push(EV_INC, 1, 8);
        push(EV_GO_BALL, 1, 13);
        push(EV_GO_BRICK, 1, 8);
        push(EV_GO_PLAT, 1, 8);
        push(EV_GO_BALL, 1, 9);                // queued frame starts right after idle
        push_rest_of_frame();
        repeat (110) @(posedge clk);
        chk("overrun_queue_drained", exp_q.size(), 0);

        // Frame 4: reset during the colour-pass ball wait.
        tick();
        t3 = tick_cyc;
        push(EV_GO_BALL, 2, t3 + 2);
        push(EV_GO_PLAT, 1, 8);
        push(EV_INC, 1, 8);
        push(EV_GO_BALL, 1, 13);
        repeat (32) @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_midframe");
        chk("reset_queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_after_reset", busy, 1'b0);

        // Frame 5: normal operation resumes after the aborted frame.
        tick();
        t4 = tick_cyc;
        push(EV_GO_BALL, 2, t4 + 2);
        push_rest_of_frame();
        repeat (60) @(posedge clk);
        chk("final_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
